// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fifo_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;

    // Default maximum words written per grant before the port is handed on.
    localparam int ARB_MAX_BURST_DEF = 8;
    // Default idle cycles tolerated inside a burst before the grant is dropped.
    localparam int ARB_GAP_MAX_DEF   = 15;

    // Tag width for n requesters; a single requester still gets a 1-bit tag.
    function automatic int tag_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Round-robin picker: first set request scanning upward from last+1, wrapping at NREQ.
// Latency: purely combinational.
// Backpressure: none; found=0 when no request is set.
module arb_rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = tag_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic            found,
    output logic [IDW-1:0]  idx
);

    // Scan offsets from farthest to nearest so the nearest valid index wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            for (int i = 0; i < NREQ; i++) begin
                if ((i == ((int'(last) + k) % NREQ)) && req[i]) begin
                    found = 1'b1;
                    idx   = IDW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one FIFO write port between NREQ requesters, tagging each word.
// Latency: one arbitration cycle in IDLE, then one word per cycle combinationally from req_valid.
// Backpressure: fifo_full stalls the granted requester in the same cycle; afull only blocks new grants.
module fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int IDW       = tag_width(NREQ),
    parameter int MAX_BURST = ARB_MAX_BURST_DEF,
    parameter int GAP_MAX   = ARB_GAP_MAX_DEF
) (
    input  logic                mclk,
    input  logic                reset_n,
    input  logic                cfg_enable,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*DW-1:0]  req_data,
    input  logic [NREQ-1:0]     req_last,
    output logic [NREQ-1:0]     req_ack,
    input  logic                fifo_full,
    input  logic                fifo_afull,
    output logic                fifo_wr_en,
    output logic [IDW+DW-1:0]   fifo_wr_data,
    output logic [IDW-1:0]      gnt_id,
    output logic                busy
);

    localparam logic [3:0] BEAT_LAST = 4'(MAX_BURST - 1);
    localparam logic [3:0] GAP_LAST  = 4'(GAP_MAX - 1);

    arb_state_t      state_q, state_d;
    logic [IDW-1:0]  last_gnt_q, last_gnt_d;
    logic [IDW-1:0]  gnt_id_q, gnt_id_d;
    logic [3:0]      beat_q, beat_d;
    logic [3:0]      gap_q, gap_d;

    logic            pick_found;
    logic [IDW-1:0]  pick_idx;
    logic            sel_valid;
    logic            sel_last;
    logic [DW-1:0]   sel_data;
    logic            xfer;

    arb_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req   (req_valid),
        .last  (last_gnt_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Select the granted requester's valid, last and payload.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_id_q == IDW'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[i*DW +: DW];
            end
        end
    end

    assign xfer = (state_q == ARB_BURST) && sel_valid && !fifo_full;

    // Write strobe, ack and tagged data follow the transfer combinationally so a full
    // FIFO stalls the word in the same cycle and the word stays at the requester.
    always_comb begin
        req_ack      = '0;
        fifo_wr_en   = xfer;
        fifo_wr_data = '0;
        if (xfer) begin
            fifo_wr_data = {gnt_id_q, sel_data};
            for (int i = 0; i < NREQ; i++) begin
                if (gnt_id_q == IDW'(i)) begin
                    req_ack[i] = 1'b1;
                end
            end
        end
    end

    assign gnt_id = gnt_id_q;
    assign busy   = (state_q == ARB_BURST);

    // Next-state: grant in IDLE, count beats and gaps in BURST, release on last/limit/gap.
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        gnt_id_d   = gnt_id_q;
        beat_d     = beat_q;
        gap_d      = gap_q;
        case (state_q)
            ARB_IDLE: begin
                // Require room for more than one word so a fresh burst never starts
                // against an almost-full FIFO; cfg_enable gates new grants only.
                if (cfg_enable && pick_found && !fifo_full && !fifo_afull) begin
                    state_d  = ARB_BURST;
                    gnt_id_d = pick_idx;
                    beat_d   = '0;
                    gap_d    = '0;
                end
            end
            ARB_BURST: begin
                if (xfer) begin
                    beat_d = beat_q + 4'd1;
                    gap_d  = '0;
                    if (sel_last || (beat_q == BEAT_LAST)) begin
                        state_d    = ARB_IDLE;
                        last_gnt_d = gnt_id_q;
                    end
                end else if (!sel_valid) begin
                    // Only an absent requester ages the grant; a full FIFO stall does not.
                    gap_d = gap_q + 4'd1;
                    if (gap_q == GAP_LAST) begin
                        state_d    = ARB_IDLE;
                        last_gnt_d = gnt_id_q;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State and counter registers; reset points the round-robin pointer so index 0 wins first.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ARB_IDLE;
            last_gnt_q <= IDW'(NREQ - 1);
            gnt_id_q   <= '0;
            beat_q     <= '0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            gnt_id_q   <= gnt_id_d;
            beat_q     <= beat_d;
            gap_q      <= gap_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb: burst, fairness, full stall, gap release, afull, reset.
// Latency: checks combinational outputs 2 time units after each rising edge.
// Backpressure: fifo_full/fifo_afull driven directly by the bench.
module tb_fifo_wr_arb;

    logic        mclk;
    logic        reset_n;
    logic        cfg_enable;
    logic [3:0]  req_valid;
    logic [3:0]  req_valid2;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic        fifo_full;
    logic        fifo_afull;

    logic [3:0]  req_ack,  req_ack2;
    logic        wr_en,    wr_en2;
    logic [9:0]  wr_data,  wr_data2;
    logic [1:0]  gnt_id,   gnt_id2;
    logic        busy,     busy2;

    int n_tests = 0;
    int n_fail  = 0;

    fifo_wr_arb u_dut (
        .mclk         (mclk),
        .reset_n      (reset_n),
        .cfg_enable   (cfg_enable),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ack      (req_ack),
        .fifo_full    (fifo_full),
        .fifo_afull   (fifo_afull),
        .fifo_wr_en   (wr_en),
        .fifo_wr_data (wr_data),
        .gnt_id       (gnt_id),
        .busy         (busy)
    );

    fifo_wr_arb #(.MAX_BURST(2)) u_dut2 (
        .mclk         (mclk),
        .reset_n      (reset_n),
        .cfg_enable   (cfg_enable),
        .req_valid    (req_valid2),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ack      (req_ack2),
        .fifo_full    (fifo_full),
        .fifo_afull   (fifo_afull),
        .fifo_wr_en   (wr_en2),
        .fifo_wr_data (wr_data2),
        .gnt_id       (gnt_id2),
        .busy         (busy2)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset_n    = 1'b0;
        cfg_enable = 1'b1;
        req_valid  = '0;
        req_valid2 = '0;
        req_data   = '0;
        req_last   = '0;
        fifo_full  = 1'b0;
        fifo_afull = 1'b0;

        // Reset state
        tick(); settle();
        chk("rst_ack",   32'(req_ack), 32'h0);
        chk("rst_wren",  32'(wr_en),   32'h0);
        chk("rst_wdata", 32'(wr_data), 32'h0);
        chk("rst_busy",  32'(busy),    32'h0);
        chk("rst_gnt",   32'(gnt_id),  32'h0);
        tick();
        reset_n = 1'b1;

        // Single requester: req 2 sends A0,A1,A2
        tick();
        req_valid = 4'b0100; req_data[23:16] = 8'hA0;
        settle();
        chk("s_idle_busy", 32'(busy),  32'h0);
        chk("s_idle_wren", 32'(wr_en), 32'h0);
        tick();
        settle();
        chk("s_a0_data", 32'(wr_data), 32'h2A0);
        chk("s_a0_ack",  32'(req_ack), 32'h4);
        chk("s_a0_gnt",  32'(gnt_id),  32'h2);
        chk("s_a0_busy", 32'(busy),    32'h1);
        tick();
        req_data[23:16] = 8'hA1;
        settle();
        chk("s_a1_data", 32'(wr_data), 32'h2A1);
        tick();
        req_data[23:16] = 8'hA2; req_last = 4'b0100;
        settle();
        chk("s_a2_data", 32'(wr_data), 32'h2A2);
        chk("s_a2_wren", 32'(wr_en),   32'h1);
        tick();
        req_valid = '0; req_last = '0;
        settle();
        chk("s_end_busy", 32'(busy),  32'h0);
        chk("s_end_wren", 32'(wr_en), 32'h0);

        // Fairness on the MAX_BURST=2 instance: IDLE, 2 beats, IDLE, ...
        tick();
        for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = 8'h10 + 8'(i);
        req_valid2 = 4'hF;
        settle();
        for (int k = 0; k < 14; k++) begin
            logic [1:0] eg;
            logic       eb;
            eb = (k % 3) != 0;
            eg = 2'(((k - 1) / 3) % 4);
            chk($sformatf("fair_busy_%0d", k), 32'(busy2), 32'(eb));
            chk($sformatf("fair_wren_%0d", k), 32'(wr_en2), 32'(eb));
            if (eb) begin
                chk($sformatf("fair_data_%0d", k), 32'(wr_data2), 32'({eg, 8'h10 + 8'(eg)}));
                chk($sformatf("fair_ack_%0d", k), 32'(req_ack2), 32'(4'b0001 << eg));
            end
            tick(); settle();
        end
        req_valid2 = '0;

        // Full stall: req 0 (last grant was 2, so 3 then 0 is scanned)
        tick();
        req_valid = 4'b0001; req_data[7:0] = 8'hB0;
        settle();
        chk("f_idle_busy", 32'(busy), 32'h0);
        tick(); settle();
        chk("f_b0_data", 32'(wr_data), 32'h0B0);
        tick();
        req_data[7:0] = 8'hB1; fifo_full = 1'b1;
        settle();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("f_stall_wren_%0d", k), 32'(wr_en),   32'h0);
            chk($sformatf("f_stall_ack_%0d", k),  32'(req_ack), 32'h0);
            chk($sformatf("f_stall_busy_%0d", k), 32'(busy),    32'h1);
            tick(); settle();
        end
        fifo_full = 1'b0;
        settle();
        chk("f_b1_wren", 32'(wr_en),   32'h1);
        chk("f_b1_data", 32'(wr_data), 32'h0B1);
        chk("f_b1_ack",  32'(req_ack), 32'h1);
        tick();
        req_data[7:0] = 8'hB2; req_last = 4'b0001;
        settle();
        chk("f_b2_data", 32'(wr_data), 32'h0B2);
        tick();
        req_valid = '0; req_last = '0;
        settle();
        chk("f_end_busy", 32'(busy), 32'h0);

        // Gap release: req 1 granted, drops for 15 cycles, req 3 waiting
        tick();
        req_valid = 4'b1010; req_data[15:8] = 8'hC0; req_data[31:24] = 8'hD0;
        settle();
        tick(); settle();
        chk("g_c0_data", 32'(wr_data), 32'h1C0);
        tick();
        req_valid = 4'b1000;
        settle();
        for (int k = 0; k < 15; k++) begin
            chk($sformatf("g_hold_busy_%0d", k), 32'(busy),  32'h1);
            chk($sformatf("g_hold_wren_%0d", k), 32'(wr_en), 32'h0);
            tick(); settle();
        end
        chk("g_rel_busy", 32'(busy), 32'h0);
        tick();
        req_last = 4'b1000;
        settle();
        chk("g_d0_gnt",  32'(gnt_id),  32'h3);
        chk("g_d0_data", 32'(wr_data), 32'h3D0);
        chk("g_d0_ack",  32'(req_ack), 32'h8);
        tick();
        req_valid = '0; req_last = '0;
        settle();
        chk("g_end_busy", 32'(busy), 32'h0);

        // afull blocks new grants but not an ongoing burst
        tick();
        fifo_afull = 1'b1; req_valid = 4'b0001; req_data[7:0] = 8'hE0;
        settle();
        for (int k = 0; k < 3; k++) begin
            tick(); settle();
            chk($sformatf("a_block_busy_%0d", k), 32'(busy), 32'h0);
        end
        fifo_afull = 1'b0;
        tick(); settle();
        chk("a_e0_busy", 32'(busy),    32'h1);
        chk("a_e0_data", 32'(wr_data), 32'h0E0);
        tick();
        fifo_afull = 1'b1; req_data[7:0] = 8'hE1;
        settle();
        chk("a_e1_wren", 32'(wr_en),   32'h1);
        chk("a_e1_data", 32'(wr_data), 32'h0E1);
        tick();
        req_data[7:0] = 8'hE2; req_last = 4'b0001;
        settle();
        chk("a_e2_data", 32'(wr_data), 32'h0E2);
        tick();
        req_valid = '0; req_last = '0; fifo_afull = 1'b0;
        settle();

        // Reset mid-burst after two words; last grant 0 so req 2 wins first
        tick();
        req_valid = 4'b0101; req_data[7:0] = 8'hF0; req_data[23:16] = 8'hF2;
        settle();
        tick(); settle();
        chk("r_w0_data", 32'(wr_data), 32'h2F2);
        tick();
        req_data[23:16] = 8'hF3;
        settle();
        chk("r_w1_data", 32'(wr_data), 32'h2F3);
        tick();
        reset_n = 1'b0;
        settle();
        chk("r_rst_wren",  32'(wr_en),   32'h0);
        chk("r_rst_ack",   32'(req_ack), 32'h0);
        chk("r_rst_wdata", 32'(wr_data), 32'h0);
        chk("r_rst_busy",  32'(busy),    32'h0);
        chk("r_rst_gnt",   32'(gnt_id),  32'h0);
        tick();
        tick();
        reset_n = 1'b1;
        settle();
        chk("r_rel_busy", 32'(busy), 32'h0);
        tick(); settle();
        chk("r_new_gnt",  32'(gnt_id),  32'h0);
        chk("r_new_data", 32'(wr_data), 32'h0F0);
        tick();
        req_valid = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
